id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands and control from the decode stage.
- Performs immediate sign-extension, operand-B selection and destination-register selection.
- Presents ALU inputs (operand A, operand B, ALUOp, funct) to the EX stage with a valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.
- IMM_W, 16, immediate width (sign-extended to DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  squash the held instruction (branch taken or exception).
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept.
- in_rs_data  in  DATA_W  register-file read A.
- in_rt_data  in  DATA_W  register-file read B.
- in_imm  in  IMM_W  raw immediate.
- in_rs_addr / in_rt_addr / in_rd_addr  in  REG_AW each  register indices.
- in_alu_op  in  3  ALUOp: 000 R-type, 001 add (lw/sw), 010 compare (beq).
- in_funct  in  6  instruction funct field.
- in_alu_src  in  1  1 selects immediate as operand B.
- in_reg_dst  in  1  1 selects rd as destination, 0 selects rt.
- in_reg_write  in  1  instruction writes the register file.
- out_valid  out  1  EX holds a valid instruction.
- out_ready  in  1  EX accepts this cycle.
- alu_in1  out  DATA_W  ALU operand A.
- alu_in2  out  DATA_W  ALU operand B.
- alu_op  out  3  registered ALUOp.
- alu_func  out  6  registered funct.
- wr_addr  out  REG_AW  selected destination register.
- reg_write  out  1  registered reg_write gated by out_valid.
- store_data  out  DATA_W  rt operand for stores.
- Under FORWARDING_EN only:
  - exmem_reg_write  in  1
  - exmem_rd  in  REG_AW
  - exmem_result  in  DATA_W
  - memwb_reg_write  in  1
  - memwb_rd  in  REG_AW
  - memwb_result  in  DATA_W

Behaviour:
- Reset (async, rst=1): out_valid=0; all registered fields 0; alu_in1=alu_in2=store_data=0; wr_addr=0; reg_write=0. Takes effect immediately, mid-transfer included; no partial capture survives.
- in_ready = !out_valid || out_ready (combinational; single-entry register, no skid buffer).
- Capture on a clock edge when in_valid && in_ready.
  - Registers rs_data, rt_data, sign-extended imm ({16{imm[15]}},imm), rs_addr, rt_addr, alu_op, funct, alu_src, reg_write.
  - Registers wr_addr = reg_dst ? rd_addr : rt_addr.
  - Sets out_valid=1.
- Drain: out_valid && out_ready && !(in_valid && in_ready) causes out_valid to clear next edge.
- Stall: out_valid && !out_ready means every register holds; in_ready=0.
- Flush: out_valid=0 next edge. Flush has priority over a simultaneous capture, which is discarded. Data registers may hold stale values. reg_write output is 0 whenever out_valid=0.
- Outputs are registered values with no added latency: an instruction accepted at edge N is presented from edge N onward until consumed.
- alu_in2 = alu_src_q ? imm_ext_q : operand_B; store_data = operand_B (never the immediate).
- alu_op and alu_func pass through unchanged; no decoding here.
- Back-to-back: a full stage with out_ready=1 and in_valid=1 replaces its contents each cycle, giving full throughput.

Optional Feature:
- Macro: MIPS_ID_EX_FORWARDING_EN.
- Defined:
  - Operand A/B are resolved combinationally from the registered rs/rt addresses.
  - Priority: EX/MEM match (exmem_reg_write && exmem_rd!=0 && exmem_rd==addr) selects exmem_result; otherwise the MEM/WB match (same rule) selects memwb_result; otherwise the registered register-file data is used.
  - Register 0 is never forwarded.
- Undefined:
  - Forwarding ports are absent.
  - Operands are the registered register-file data only; hazards are handled by upstream stalls.

Decomposition:
- Shared package mips_pkg holds:
  - ALUOp encodings ALUOP_RTYPE=3'b000, ALUOP_ADD=3'b001, ALUOP_CMP=3'b010.
  - FUNCT_ADD=6'b100000.
  - DATA_W, REG_AW, IMM_W defaults.
  - REG_ZERO=0.
- One sub-module, id_ex_fwd_mux: takes addr, regfile data and both forwarding sources; outputs the resolved operand. It is instantiated twice (A, B) under the macro.

Test Plan:
- Reset mid-stall: load, hold out_ready=0, assert rst → out_valid=0, all outputs 0 immediately, before the next edge.
- I-type capture: imm=16'hFFFC, alu_src=1, rs_data=0x100, reg_dst=0, rt=5 → alu_in1=0x100, alu_in2=0xFFFFFFFC, wr_addr=5, alu_op=001.
- Stall/hold: out_ready=0 for 3 cycles with new in_valid → in_ready=0, outputs unchanged; out_ready=1 → next instruction loaded the same edge.
- Flush with simultaneous capture: flush=1, in_valid=1, in_ready=1 → out_valid=0 and reg_write=0 next cycle.
- Forwarding (macro on): rs=3, exmem_rd=3, exmem_result=0xAA, memwb_rd=3, memwb_result=0xBB → alu_in1=0xAA. With exmem_rd=0 targeting reg 0 and rs=0 → regfile value kept.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALUOp and funct encodings, default widths, zero register.
// Imported by the ID/EX stage and its forwarding mux.
package mips_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_IMM_W  = 16;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_CMP   = 3'b010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    localparam int REG_ZERO = 0;
endpackage

// File: rtl/id_ex_fwd_mux.sv
// Combinational operand resolver: EX/MEM result, else MEM/WB result, else register-file data.
// Zero latency, no flow control; register 0 is never forwarded.
module id_ex_fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
)(
    input  logic [REG_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exmem_reg_write,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data
);
    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd != REG_AW'(REG_ZERO)) && (i_exmem_rd == i_addr);
    assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd != REG_AW'(REG_ZERO)) && (i_memwb_rd == i_addr);

    always_comb begin
        o_data = i_rf_data;
        if (w_exmem_hit) begin
            o_data = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_data = i_memwb_result;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU; 0-cycle presentation of a captured instruction, single entry, stalls when EX not ready.
// Optional operand forwarding from EX/MEM and MEM/WB under `MIPS_ID_EX_FORWARDING_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int IMM_W  = DEF_IMM_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [2:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic              in_alu_src,
    input  logic              in_reg_dst,
    input  logic              in_reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_op,
    output logic [5:0]        alu_func,
    output logic [REG_AW-1:0] wr_addr,
    output logic              reg_write,
    output logic [DATA_W-1:0] store_data
`ifdef MIPS_ID_EX_FORWARDING_EN
    ,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result
`endif
);
    logic              r_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm_ext;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_wr_addr;
    logic [2:0]        r_alu_op;
    logic [5:0]        r_funct;
    logic              r_alu_src;
    logic              r_reg_write;

    logic              w_cap;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign in_ready = !r_valid || out_ready;
    assign w_cap    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm_ext   <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_wr_addr   <= '0;
            r_alu_op    <= '0;
            r_funct     <= '0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            // A flush discards a same-cycle capture; data regs keep stale contents.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_cap) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end

            if (w_cap && !flush) begin
                r_rs_data   <= in_rs_data;
                r_rt_data   <= in_rt_data;
                r_imm_ext   <= {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
                r_rs_addr   <= in_rs_addr;
                r_rt_addr   <= in_rt_addr;
                r_wr_addr   <= in_reg_dst ? in_rd_addr : in_rt_addr;
                r_alu_op    <= in_alu_op;
                r_funct     <= in_funct;
                r_alu_src   <= in_alu_src;
                r_reg_write <= in_reg_write;
            end
        end
    end

`ifdef MIPS_ID_EX_FORWARDING_EN
    id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .i_addr            (r_rs_addr),
        .i_rf_data         (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_op_a)
    );

    id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .i_addr            (r_rt_addr),
        .i_rf_data         (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_op_b)
    );
`else
    // Source addresses only matter for forwarding; hazards are stalled upstream.
    logic w_unused_addr;
    assign w_unused_addr = ^{r_rs_addr, r_rt_addr};
    assign w_op_a        = r_rs_data;
    assign w_op_b        = r_rt_data;
`endif

    assign out_valid  = r_valid;
    assign alu_in1    = w_op_a;
    assign alu_in2    = r_alu_src ? r_imm_ext : w_op_b;
    assign store_data = w_op_b;
    assign alu_op     = r_alu_op;
    assign alu_func   = r_funct;
    assign wr_addr    = r_wr_addr;
    assign reg_write  = r_reg_write && r_valid;
endmodule
